// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU opcode encoding and RV32I decode constants for the ALU issue stage.
package alu_issue_stage_pkg;

    localparam int ALU_OP_LENGTH = 4;

    typedef enum logic [ALU_OP_LENGTH-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU implementing every alu_op_t code; shift amount is right[log2(XLEN)-1:0].
module alu
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] left,
    input  logic [XLEN-1:0] right,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] left_s;
    logic signed [XLEN-1:0] right_s;
    logic        [SHW-1:0]  shamt;

    assign left_s  = left;
    assign right_s = right;
    assign shamt   = right[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_OP_ADD:  result = left + right;
            ALU_OP_SUB:  result = left - right;
            ALU_OP_AND:  result = left & right;
            ALU_OP_OR:   result = left | right;
            ALU_OP_XOR:  result = left ^ right;
            ALU_OP_SLL:  result = left << shamt;
            ALU_OP_SRL:  result = left >> shamt;
            ALU_OP_SRA:  result = left_s >>> shamt;
            ALU_OP_SLT:  result = {{(XLEN-1){1'b0}}, (left_s < right_s)};
            ALU_OP_SLTU: result = {{(XLEN-1){1'b0}}, (left < right)};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_decoder.sv
// Decodes RV32I OP / OP-IMM words into an ALU opcode, immediate select and legality flag.
module alu_decoder
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     alu_op,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rs1;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];
    assign unused_rs1 = ^instr[19:15];

    always_comb begin
        alu_op  = ALU_OP_ADD;
        use_imm = 1'b0;
        imm     = sext12(instr[31:20]);
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        3'b000:  alu_op = ALU_OP_ADD;
                        3'b001:  alu_op = ALU_OP_SLL;
                        3'b010:  alu_op = ALU_OP_SLT;
                        3'b011:  alu_op = ALU_OP_SLTU;
                        3'b100:  alu_op = ALU_OP_XOR;
                        3'b101:  alu_op = ALU_OP_SRL;
                        3'b110:  alu_op = ALU_OP_OR;
                        default: alu_op = ALU_OP_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    alu_op = ALU_OP_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    alu_op = ALU_OP_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_OP_ADD;
                    3'b010: alu_op = ALU_OP_SLT;
                    3'b011: alu_op = ALU_OP_SLTU;
                    3'b100: alu_op = ALU_OP_XOR;
                    3'b110: alu_op = ALU_OP_OR;
                    3'b111: alu_op = ALU_OP_AND;
                    3'b001: begin
                        // Shift immediates carry only the 5-bit amount; the upper field is an opcode extension.
                        imm     = {27'b0, instr[24:20]};
                        alu_op  = ALU_OP_SLL;
                        illegal = (funct7 != FUNCT7_BASE);
                    end
                    default: begin
                        imm     = {27'b0, instr[24:20]};
                        alu_op  = (funct7 == FUNCT7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
                        illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd = illegal ? 5'd0 : instr[11:7];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage execute front-end: decode register (S1) feeding one ALU, then a result register (S2),
// with valid/ready handshakes on both sides.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    alu_op_t         dec_op;
    logic            dec_use_imm;
    logic [31:0]     dec_imm;
    logic [4:0]      dec_rd;
    logic            dec_illegal;

    logic            vld_p1;
    alu_op_t         alu_op_p1;
    logic [XLEN-1:0] left_p1;
    logic [XLEN-1:0] right_p1;
    logic [4:0]      rd_p1;
    logic            illegal_p1;

    logic            vld_p2;
    logic [XLEN-1:0] result_p2;
    logic [4:0]      rd_p2;
    logic            illegal_p2;

    logic            s2_can_load;
    logic [XLEN-1:0] alu_result;

    assign s2_can_load = !vld_p2 || out_ready;
    assign in_ready    = !vld_p1 || s2_can_load;

    alu_decoder u_decoder (
        .instr   (in_instr),
        .alu_op  (dec_op),
        .use_imm (dec_use_imm),
        .imm     (dec_imm),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    // S1: decode register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            alu_op_p1  <= dec_op;
            left_p1    <= in_rs1_val;
            right_p1   <= dec_use_imm ? dec_imm : in_rs2_val;
            rd_p1      <= dec_rd;
            illegal_p1 <= dec_illegal;
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_op_p1),
        .left   (left_p1),
        .right  (right_p1),
        .result (alu_result)
    );

    // S2: result register, held stable while writeback stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2     <= 1'b0;
            result_p2  <= '0;
            rd_p2      <= 5'd0;
            illegal_p2 <= 1'b0;
        end else if (s2_can_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2  <= illegal_p1 ? '0 : alu_result;
                rd_p2      <= rd_p1;
                illegal_p2 <= illegal_p1;
            end
        end
    end

    assign out_valid   = vld_p2;
    assign out_result  = result_p2;
    assign out_rd      = rd_p2;
    assign out_illegal = illegal_p2;

endmodule
